// File: rtl/phase_sampler_pkg.sv
// Shared definitions for the phase sampler: FSM state encoding and a
// ceiling-log2 helper used to size the sample counter.
package phase_sampler_pkg;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MEASURE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = S_IDLE,
    ST_MEASURE = S_MEASURE,
    ST_DONE    = S_DONE
  } state_t;

  function automatic int clog2(input int value);
    int width;
    width = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/sample_sync.sv
// Single-bit synchroniser: a STAGES-deep flop chain that brings an
// asynchronous oscillator output into the clk domain.
module sample_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chain_reg <= '0;
    end else begin
      chain_reg[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain_reg[i] <= chain_reg[i-1];
      end
    end
  end

  assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/phase_sampler.sv
// Per-spin phase sampler: counts ver/hor disagreements over a fixed window
// and reports saturating counts plus an in-phase decision against a cutoff.
module phase_sampler
  import phase_sampler_pkg::*;
#(
  parameter int N           = 3,
  parameter int COUNT_W     = 8,
  parameter int WINDOW      = 128,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 continuous,
  input  logic [COUNT_W-1:0]   cutoff,
  input  logic [N-1:0]         outputs_ver,
  input  logic [N-1:0]         outputs_hor,
  output logic                 busy,
  output logic                 valid,
  output logic [N-1:0]         phase,
  output logic [N*COUNT_W-1:0] mismatch_count
);

  localparam int SCNT_W = clog2(WINDOW + 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX   = '1;
  localparam logic [SCNT_W-1:0]  LAST_SAMPLE = SCNT_W'(WINDOW - 1);

  state_t              state_reg;
  logic [SCNT_W-1:0]   sample_cnt_reg;
  logic [COUNT_W-1:0]  cutoff_reg;
  logic                busy_reg;
  logic                valid_reg;

  logic [N-1:0] sync_ver;
  logic [N-1:0] sync_hor;
  logic [N-1:0] mismatch;
  logic         arm;
  logic         last_sample;

  // arm marks every entry into MEASURE: counters clear, cutoff is captured
  assign arm         = ((state_reg == ST_IDLE) && start) ||
                       ((state_reg == ST_DONE) && continuous);
  assign last_sample = (state_reg == ST_MEASURE) && (sample_cnt_reg == LAST_SAMPLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= ST_IDLE;
      sample_cnt_reg <= '0;
      cutoff_reg     <= '0;
      busy_reg       <= 1'b0;
      valid_reg      <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            cutoff_reg     <= cutoff;
            sample_cnt_reg <= '0;
            busy_reg       <= 1'b1;
            state_reg      <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          sample_cnt_reg <= sample_cnt_reg + 1'b1;
          if (last_sample) begin
            valid_reg <= 1'b1;
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (continuous) begin
            cutoff_reg     <= cutoff;
            sample_cnt_reg <= '0;
            state_reg      <= ST_MEASURE;
          end else begin
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_reg;
  assign valid = valid_reg;

  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    logic [COUNT_W-1:0] count_reg;
    logic [COUNT_W-1:0] count_next;
    logic [COUNT_W-1:0] result_reg;
    logic               phase_reg;

    sample_sync #(.STAGES(SYNC_STAGES)) u_sync_ver (
      .clk  (clk),
      .rstn (rstn),
      .d    (outputs_ver[gi]),
      .q    (sync_ver[gi])
    );

    sample_sync #(.STAGES(SYNC_STAGES)) u_sync_hor (
      .clk  (clk),
      .rstn (rstn),
      .d    (outputs_hor[gi]),
      .q    (sync_hor[gi])
    );

    assign mismatch[gi] = sync_ver[gi] ^ sync_hor[gi];

    // Saturate instead of wrapping so narrow counters still read "many".
    assign count_next = (count_reg == COUNT_MAX) ? count_reg
                                                 : count_reg + COUNT_W'(mismatch[gi]);

    // Results are latched on the final sample so they are visible in DONE.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        count_reg  <= '0;
        result_reg <= '0;
        phase_reg  <= 1'b0;
      end else begin
        if (arm) begin
          count_reg <= '0;
        end else if (state_reg == ST_MEASURE) begin
          count_reg <= count_next;
        end
        if (last_sample) begin
          result_reg <= count_next;
          phase_reg  <= (count_next < cutoff_reg);
        end
      end
    end

    assign mismatch_count[gi*COUNT_W +: COUNT_W] = result_reg;
    assign phase[gi]                             = phase_reg;
  end

endmodule

// File: tb/tb_phase_sampler.sv
// Randomised and directed bench for phase_sampler; a timeline model of the
// measurement windows predicts busy/valid/phase/counts every cycle.
module tb_phase_sampler;

  localparam int N    = 3;
  localparam int W    = 8;
  localparam int S    = 2;
  localparam int HMAX = 4096;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       start = 1'b0;
  logic       continuous = 1'b0;
  logic [7:0] cutoff = '0;
  logic [2:0] cutoff_b = '0;
  logic [2:0] ver = '0;
  logic [2:0] hor = '0;

  logic        busy_a, valid_a, busy_b, valid_b;
  logic [2:0]  phase_a, phase_b;
  logic [23:0] cnt_a;
  logic [8:0]  cnt_b;

  always #5 clk = ~clk;

  phase_sampler #(.N(N), .COUNT_W(8), .WINDOW(W), .SYNC_STAGES(S)) dut_a (
    .clk            (clk),
    .rstn           (rstn),
    .start          (start),
    .continuous     (continuous),
    .cutoff         (cutoff),
    .outputs_ver    (ver),
    .outputs_hor    (hor),
    .busy           (busy_a),
    .valid          (valid_a),
    .phase          (phase_a),
    .mismatch_count (cnt_a)
  );

  phase_sampler #(.N(N), .COUNT_W(3), .WINDOW(W), .SYNC_STAGES(S)) dut_b (
    .clk            (clk),
    .rstn           (rstn),
    .start          (start),
    .continuous     (continuous),
    .cutoff         (cutoff_b),
    .outputs_ver    (ver),
    .outputs_hor    (hor),
    .busy           (busy_b),
    .valid          (valid_b),
    .phase          (phase_b),
    .mismatch_count (cnt_b)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int win_s   = 0;
  int vq[$];

  // hist_mm[c] = mismatch pattern driven in cycle c (zero while in reset)
  logic [2:0] hist_mm [HMAX];
  bit         m_active = 1'b0;
  int         m_start  = 0;
  int         m_cut    = 0;
  int         m_cut3   = 0;

  logic        e_busy, e_valid;
  logic [2:0]  e_phase_a = '0, e_phase_b = '0;
  logic [23:0] e_cnt_a = '0;
  logic [8:0]  e_cnt_b = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  // Window started in cycle s samples, through S sync flops, the inputs of
  // cycles s+1-S .. s+W-S.
  function automatic int window_sum(input int ch, input int s);
    int sum = 0;
    for (int c = s + 1; c <= s + W; c++) begin
      if (c - S >= 0 && hist_mm[c-S][ch]) sum++;
    end
    return sum;
  endfunction

  task automatic tick(input logic rn, input logic st, input logic co,
                      input logic [7:0] cu, input logic [2:0] cu3,
                      input logic [2:0] vv, input logic [2:0] hh);
    int sum, sa, sb;
    @(posedge clk);
    cyc++;
    #1;
    e_busy  = m_active && (cyc > m_start);
    e_valid = m_active && (cyc == m_start + W + 1);
    if (e_valid) begin
      for (int ch = 0; ch < N; ch++) begin
        sum = window_sum(ch, m_start);
        sa  = (sum > 255) ? 255 : sum;
        sb  = (sum > 7) ? 7 : sum;
        e_cnt_a[ch*8 +: 8] = 8'(sa);
        e_cnt_b[ch*3 +: 3] = 3'(sb);
        e_phase_a[ch]      = (sa < m_cut);
        e_phase_b[ch]      = (sb < m_cut3);
      end
    end
    chk("busy_a",  32'(busy_a),  32'(e_busy));
    chk("valid_a", 32'(valid_a), 32'(e_valid));
    chk("phase_a", 32'(phase_a), 32'(e_phase_a));
    chk("count_a", 32'(cnt_a),   32'(e_cnt_a));
    chk("busy_b",  32'(busy_b),  32'(e_busy));
    chk("valid_b", 32'(valid_b), 32'(e_valid));
    chk("phase_b", 32'(phase_b), 32'(e_phase_b));
    chk("count_b", 32'(cnt_b),   32'(e_cnt_b));
    if (valid_a) vq.push_back(cyc);

    rstn       = rn;
    start      = st;
    continuous = co;
    cutoff     = cu;
    cutoff_b   = cu3;
    ver        = vv;
    hor        = hh;
    hist_mm[cyc] = rn ? (vv ^ hh) : 3'b000;

    if (!rn) begin
      m_active  = 1'b0;
      e_cnt_a   = '0;
      e_cnt_b   = '0;
      e_phase_a = '0;
      e_phase_b = '0;
      #1;
      chk("rst_busy",  32'(busy_a),  32'd0);
      chk("rst_valid", 32'(valid_a), 32'd0);
      chk("rst_phase", 32'(phase_a), 32'd0);
      chk("rst_count", 32'(cnt_a),   32'd0);
    end else if (!m_active) begin
      if (st) begin
        m_active = 1'b1;
        m_start  = cyc;
        m_cut    = int'(cu);
        m_cut3   = int'(cu3);
      end
    end else if (cyc == m_start + W + 1) begin
      if (co) begin
        m_start = cyc;
        m_cut   = int'(cu);
        m_cut3  = int'(cu3);
      end else begin
        m_active = 1'b0;
      end
    end
  endtask

  // Settle inputs, pulse start once, run past the result, expect one valid.
  task automatic run_window(input string tag, input logic [7:0] cu, input logic [2:0] cu3,
                            input logic [2:0] vv, input logic [2:0] hh);
    vq.delete();
    repeat (3) tick(1'b1, 1'b0, 1'b0, cu, cu3, vv, hh);
    tick(1'b1, 1'b1, 1'b0, cu, cu3, vv, hh);
    win_s = cyc;
    repeat (11) tick(1'b1, 1'b0, 1'b0, cu, cu3, vv, hh);
    chk({tag, "_nvalid"}, 32'(vq.size()), 32'd1);
    if (vq.size() > 0) chk({tag, "_vcycle"}, 32'(vq[0] - win_s), 32'd9);
  endtask

  // Channel 2 ver toggles every cycle; cutoff changes to cu_late mid-window.
  task automatic run_toggle(input string tag, input logic [7:0] cu, input logic [7:0] cu_late);
    logic [2:0] vv = 3'b000;
    for (int k = -3; k <= 11; k++) begin
      vv[2] = ~vv[2];
      tick(1'b1, (k == 0), 1'b0, (k > 4) ? cu_late : cu, 3'd4, vv, 3'b000);
      if (k == 0) win_s = cyc;
    end
    chk({tag, "_count2"}, 32'(cnt_a[23:16]), 32'd4);
    chk({tag, "_count01"}, 32'(cnt_a[15:0]), 32'd0);
  endtask

  initial begin
    logic [2:0] rv, rh;
    for (int i = 0; i < HMAX; i++) hist_mm[i] = 3'b000;
    #1 rstn = 1'b0;

    // Reset from power-up, then abort a window with reset mid-way.
    repeat (3) tick(1'b0, 1'b0, 1'b0, 8'd4, 3'd4, 3'b000, 3'b000);
    repeat (4) tick(1'b1, 1'b0, 1'b0, 8'd4, 3'd4, 3'b011, 3'b000);
    tick(1'b1, 1'b1, 1'b0, 8'd4, 3'd4, 3'b011, 3'b000);
    repeat (4) tick(1'b1, 1'b0, 1'b0, 8'd4, 3'd4, 3'b011, 3'b000);
    vq.delete();
    tick(1'b0, 1'b0, 1'b0, 8'd4, 3'd4, 3'b011, 3'b000);
    repeat (12) tick(1'b1, 1'b0, 1'b0, 8'd4, 3'd4, 3'b011, 3'b000);
    chk("abort_nvalid", 32'(vq.size()), 32'd0);

    // All channels in phase.
    run_window("t2", 8'd4, 3'd4, 3'b101, 3'b101);
    chk("t2_count", 32'(cnt_a), 32'd0);
    chk("t2_phase", 32'(phase_a), 32'b111);

    // Channel 1 permanently out of phase.
    run_window("t3", 8'd4, 3'd4, 3'b010, 3'b000);
    chk("t3_count", 32'(cnt_a), 32'h000800);
    chk("t3_phase", 32'(phase_a), 32'b101);

    // Half-duty mismatch against cutoffs 4 and 5; late cutoff change ignored.
    run_toggle("t4a", 8'd4, 8'd4);
    chk("t4a_phase2", 32'(phase_a[2]), 32'd0);
    run_toggle("t4b", 8'd5, 8'd5);
    chk("t4b_phase2", 32'(phase_a[2]), 32'd1);
    run_toggle("t4c", 8'd5, 8'd0);
    chk("t4c_phase2", 32'(phase_a[2]), 32'd1);

    // Saturation in the 3-bit instance, equality case in the 8-bit one.
    run_window("t5", 8'd8, 3'd7, 3'b001, 3'b000);
    chk("t5_sat_count0", 32'(cnt_b[2:0]), 32'd7);
    chk("t5_sat_phase0", 32'(phase_b[0]), 32'd0);
    chk("t5_eq_count0", 32'(cnt_a[7:0]), 32'd8);
    chk("t5_eq_phase0", 32'(phase_a[0]), 32'd0);
    run_window("t5z", 8'd0, 3'd0, 3'b001, 3'b000);
    chk("t5z_phase", 32'(phase_a), 32'd0);

    // Continuous mode, held for four windows with stray starts while busy.
    vq.delete();
    tick(1'b1, 1'b1, 1'b1, 8'd3, 3'd3, 3'b110, 3'b010);
    win_s = cyc;
    for (int k = 1; k <= 40; k++)
      tick(1'b1, (k == 5 || k == 20), (k <= 28), 8'd3, 3'd3, 3'b110, 3'b010);
    chk("t6a_nvalid", 32'(vq.size()), 32'd4);
    for (int i = 0; i < 4 && i < vq.size(); i++)
      chk("t6a_vcycle", 32'(vq[i] - win_s), 32'(9 * (i + 1)));
    chk("t6a_busy_end", 32'(busy_a), 32'd0);

    // Continuous dropped in cycle 12: last valid at 18, then idle.
    vq.delete();
    tick(1'b1, 1'b1, 1'b1, 8'd5, 3'd5, 3'b001, 3'b100);
    win_s = cyc;
    for (int k = 1; k <= 25; k++)
      tick(1'b1, (k == 3 || k == 14), (k < 12), 8'd5, 3'd5, 3'b001, 3'b100);
    chk("t6b_nvalid", 32'(vq.size()), 32'd2);
    for (int i = 0; i < 2 && i < vq.size(); i++)
      chk("t6b_vcycle", 32'(vq[i] - win_s), 32'(9 * (i + 1)));
    chk("t6b_busy_end", 32'(busy_a), 32'd0);

    // Random traffic checked cycle-by-cycle against the model.
    rv = 3'b000;
    rh = 3'b000;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 3) == 0) rv = 3'($urandom);
      if ($urandom_range(0, 3) == 0) rh = 3'($urandom);
      tick(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) != 0), 8'($urandom_range(0, 10)),
           3'($urandom_range(0, 7)), rv, rh);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/phase_sampler.md
Name: phase_sampler

Overview:
Parametrised successor to the spin phase sampler. It measures, per spin, how often the spin's oscillator output (outputs_ver) disagrees with its local field (outputs_hor) over a fixed sampling window. The block reports saturating mismatch counts and a thresholded in-phase/out-of-phase decision. It sits between the oscillator array and the readout/annealing controller, and supports both single-shot and continuous windowed measurement.

Parameters:
N, 3, number of spins/channels
COUNT_W, 8, width of each per-channel mismatch counter; must satisfy 2^COUNT_W-1 >= WINDOW for exact counts (smaller widths are legal and saturate)
WINDOW, 128, samples per measurement window; >= 1
SYNC_STAGES, 2, synchroniser flops per asynchronous oscillator input; >= 1

Ports:
clk  in  1  sampling clock
rstn  in  1  asynchronous active-low reset
start  in  1  begin a window; honoured only in IDLE
continuous  in  1  1 = re-arm automatically after each window; sampled in DONE
cutoff  in  COUNT_W  mismatch threshold; captured at window start
outputs_ver  in  N  spin oscillator outputs, asynchronous to clk
outputs_hor  in  N  local-field oscillator outputs, asynchronous to clk
busy  out  1  high in MEASURE and DONE
valid  out  1  one-cycle pulse when results update
phase  out  N  1 = in-phase with local field (count < captured cutoff), 0 = out-of-phase
mismatch_count  out  N*COUNT_W  channel i occupies bits [i*COUNT_W +: COUNT_W]; last completed window

Behaviour:
- Reset (async, rstn=0): FSM=IDLE; synchronisers, working counters, sample counter and captured cutoff cleared; busy=0, valid=0, phase=0, mismatch_count=0.
- Synchronisation: every bit of outputs_ver/outputs_hor passes through SYNC_STAGES flops. mismatch[i] = sync_ver[i] ^ sync_hor[i].
- FSM states: IDLE, MEASURE, DONE.
  - IDLE: if start=1, capture cutoff, clear working counters and sample counter, then go to MEASURE.
  - MEASURE: each cycle, working count[i] += mismatch[i], saturating at 2^COUNT_W-1 (never wraps); sample counter increments. After the WINDOW-th sample, go to DONE.
  - DONE (exactly one cycle): mismatch_count <= working counts; phase[i] <= (working count[i] < captured cutoff); valid=1. Next state is MEASURE if continuous=1 (recapture cutoff, clear counters), else IDLE.
- Timing: start high in cycle 0 gives MEASURE in cycles 1..WINDOW, valid and new outputs in cycle WINDOW+1. In continuous mode the window period is WINDOW+1 cycles.
- Outputs phase and mismatch_count are registered and hold between valid pulses.
- start while busy=1 is ignored (not queued). start held high in IDLE starts only one window per IDLE visit.
- Changing cutoff mid-window has no effect on that window.
- Deasserting continuous mid-window lets the current window finish, then the FSM returns to IDLE.
- rstn asserted mid-window aborts the window immediately; no valid pulse is issued.
- Equality case: count == cutoff gives phase=0. cutoff=0 forces phase=0.

Decomposition:
- Shared package: state encoding localparams (IDLE/MEASURE/DONE) and a clog2 helper for the sample-counter width (clog2(WINDOW+1)).
- One sub-module: sample_sync, a 1-bit parametrised SYNC_STAGES flop chain with async active-low reset to 0, instantiated 2*N times.
- Per-channel saturating counters are a generate loop in the top module.

Test Plan (WINDOW=8, COUNT_W=8, SYNC_STAGES=2, N=3 unless stated):
1. Apply rstn low mid-operation, then release. Required: busy=0, valid=0, phase=000, mismatch_count=0 immediately; FSM idles until start.
2. Set ver=hor=3'b101 (static), cutoff=4, pulse start at cycle 0. Required: valid only in cycle 9; counts 0/0/0; phase=111; busy high cycles 1-9.
3. Set ver=3'b010, hor=3'b000 (static, settled through the synchroniser). Required: count[1]=8 with phase[1]=0; count[0]=count[2]=0 with phase=1.
4. Toggle channel 2 ver every clk with hor=0, cutoff=4. Required: count[2]=4 and phase[2]=0. Repeat with cutoff=5: phase[2]=1. Changing cutoff mid-window to 0 leaves the result unchanged.
5. Use COUNT_W=3, WINDOW=8, channel 0 permanently mismatched. Required: count[0]=7 (saturated, not 0) and phase[0]=0 for cutoff=7.
6. Set continuous=1 and pulse start once. Required: valid pulses at cycles 9, 18, 27. Extra start pulses while busy cause no change. Dropping continuous in cycle 12 produces a final valid at cycle 18, then busy=0.
